// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT frame sequencer
package fft_pkg;
   typedef enum logic [1:0] {IDLE, FILL, RUN, WAIT} seq_state_t;
   // Channel tag width: a single channel still needs a one-bit tag port
   function automatic int ch_width(int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: frame register file with one write port and a registered read port
module fft_frame_buf #(
   parameter int DATA_W   = 16,
   parameter int N_POINTS = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_wr_en,
   input  logic [$clog2(N_POINTS)-1:0] i_wr_addr,
   input  logic [DATA_W-1:0]           i_wr_data,
   input  logic                        i_rd_en,
   input  logic [$clog2(N_POINTS)-1:0] i_rd_addr,
   output logic [DATA_W-1:0]           o_rd_data
);
   logic [DATA_W-1:0] r_mem [N_POINTS];
   // Sample storage, written as samples are accepted
   always_ff @(posedge i_clk)
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   // Read register holds its value whenever no read is issued
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) o_rd_data <= '0;
      else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: collects one single-channel frame and replays it into the FFT core
module fft_frame_sequencer
   import fft_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int N_POINTS = 8,
   parameter int CHANNELS = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ch_width(CHANNELS)-1:0]   in_channel,
   input  logic [DATA_W-1:0]               in_sample,
   output logic                            core_enable,
   output logic [DATA_W-1:0]               core_sample,
   output logic [$clog2(N_POINTS)-1:0]     core_index,
   input  logic                            core_finish,
   output logic                            frame_done,
   output logic [ch_width(CHANNELS)-1:0]   frame_channel,
   output logic                            timeout_err,
   output logic                            mismatch_err
);
   localparam int IDX_W = $clog2(N_POINTS);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
   seq_state_t       r_state;
   logic [IDX_W-1:0] r_wr_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic             w_accept, w_match, w_last, w_wr_en, w_rd_en;
   logic [IDX_W-1:0] w_wr_addr, w_rd_addr;
   assign in_ready  = (r_state == IDLE) || (r_state == FILL);
   assign w_accept  = in_valid && in_ready;
   assign w_match   = in_channel == frame_channel;
   assign w_wr_en   = w_accept && ((r_state == IDLE) || w_match);
   assign w_wr_addr = (r_state == IDLE) ? '0 : r_wr_cnt;
   assign w_last    = (r_state == FILL) && w_accept && w_match && (r_wr_cnt == LAST_IDX);
   // Read address runs one ahead of core_index so core_sample comes out of a register
   assign w_rd_en   = w_last || ((r_state == RUN) && (core_index != LAST_IDX));
   assign w_rd_addr = w_last ? '0 : core_index + IDX_W'(1);
   fft_frame_buf #(.DATA_W(DATA_W), .N_POINTS(N_POINTS)) u_buf (
      .i_clk     (CLK),
      .i_rst     (RESET),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (in_sample),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (core_sample)
   );
   // Frame FSM with registered core strobes and completion/error flags
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         r_state       <= IDLE;
         r_wr_cnt      <= '0;
         r_to_cnt      <= '0;
         core_enable   <= 1'b0;
         core_index    <= '0;
         frame_done    <= 1'b0;
         frame_channel <= '0;
         timeout_err   <= 1'b0;
         mismatch_err  <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               frame_channel <= in_channel;
               r_wr_cnt      <= IDX_W'(1);
               r_state       <= FILL;
            end
            FILL: if (w_accept) begin
               if (!w_match) mismatch_err <= 1'b1;
               else if (w_last) begin
                  r_wr_cnt    <= '0;
                  core_enable <= 1'b1;
                  core_index  <= '0;
                  r_state     <= RUN;
               end else r_wr_cnt <= r_wr_cnt + IDX_W'(1);
            end
            RUN: if (core_index == LAST_IDX) begin
               core_enable <= 1'b0;
               r_to_cnt    <= '0;
               r_state     <= WAIT;
            end else core_index <= core_index + IDX_W'(1);
            WAIT: if (core_finish) begin
               frame_done <= 1'b1;
               r_state    <= IDLE;
            end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
               timeout_err <= 1'b1;
               r_state     <= IDLE;
            end else r_to_cnt <= r_to_cnt + TO_W'(1);
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed checks of the frame sequencer at default and wide parameters
module tb_fft_frame_sequencer;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [0:0]  in_channel = '0;
   logic [15:0] in_sample = '0;
   logic        core_enable;
   logic [15:0] core_sample;
   logic [2:0]  core_index;
   logic        core_finish = 1'b0;
   logic        frame_done;
   logic [0:0]  frame_channel;
   logic        timeout_err;
   logic        mismatch_err;
   logic        p_in_valid = 1'b0;
   logic        p_in_ready;
   logic [1:0]  p_in_channel = '0;
   logic [23:0] p_in_sample = '0;
   logic        p_core_enable;
   logic [23:0] p_core_sample;
   logic [3:0]  p_core_index;
   logic        p_core_finish = 1'b0;
   logic        p_frame_done;
   logic [1:0]  p_frame_channel;
   logic        p_timeout_err;
   logic        p_mismatch_err;
   int n_vec = 0;
   int n_err = 0;
   int exp_q [16];

   always #5 CLK = ~CLK;

   fft_frame_sequencer u_dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .in_channel(in_channel), .in_sample(in_sample), .core_enable(core_enable),
      .core_sample(core_sample), .core_index(core_index), .core_finish(core_finish),
      .frame_done(frame_done), .frame_channel(frame_channel), .timeout_err(timeout_err),
      .mismatch_err(mismatch_err)
   );

   fft_frame_sequencer #(.DATA_W(24), .N_POINTS(16), .CHANNELS(4), .TIMEOUT(64)) u_dut16 (
      .CLK(CLK), .RESET(RESET), .in_valid(p_in_valid), .in_ready(p_in_ready),
      .in_channel(p_in_channel), .in_sample(p_in_sample), .core_enable(p_core_enable),
      .core_sample(p_core_sample), .core_index(p_core_index), .core_finish(p_core_finish),
      .frame_done(p_frame_done), .frame_channel(p_frame_channel), .timeout_err(p_timeout_err),
      .mismatch_err(p_mismatch_err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input int ch, input int val);
      int w = 0;
      in_valid   = 1'b1;
      in_channel = 1'(ch);
      in_sample  = 16'(val);
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      chk("send_rdy", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_run();
      for (int k = 0; k < 8; k++) begin
         chk("run_en", int'(core_enable), 1);
         chk("run_idx", int'(core_index), k);
         chk("run_smp", int'($signed(core_sample)), exp_q[k]);
         chk("run_rdy", int'(in_ready), 0);
         tick();
      end
      chk("wait_en", int'(core_enable), 0);
      chk("wait_idx_hold", int'(core_index), 7);
   endtask

   task automatic finish(input int dly, input int ch);
      repeat (dly) begin
         chk("wait_done_lo", int'(frame_done), 0);
         tick();
      end
      core_finish = 1'b1;
      tick();
      core_finish = 1'b0;
      chk("done_hi", int'(frame_done), 1);
      chk("done_ch", int'(frame_channel), ch);
      chk("done_rdy", int'(in_ready), 1);
      chk("done_no_to", int'(timeout_err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_en", int'(core_enable), 0);
      chk("rst_smp", int'(core_sample), 0);
      chk("rst_idx", int'(core_index), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_fch", int'(frame_channel), 0);
      chk("rst_to", int'(timeout_err), 0);
      chk("rst_mm", int'(mismatch_err), 0);
      chk("rst_p_en", int'(p_core_enable), 0);
      #12 RESET = 1'b0;
      tick();
      chk("rst_rdy", int'(in_ready), 1);
      // basic frame: channel 1, samples 1..8, finish five cycles into WAIT
      for (int k = 0; k < 8; k++) begin
         exp_q[k] = k + 1;
         send(1, k + 1);
      end
      check_run();
      finish(5, 1);
      tick();
      chk("basic_done_lo", int'(frame_done), 0);
      chk("basic_mm", int'(mismatch_err), 0);
      // stalls with one foreign-channel sample
      for (int k = 0; k < 8; k++) begin
         exp_q[k] = k * 1000 - 3500;
         if (k > 0) tick();
         if (k == 3) begin
            send(1, 21845);
            chk("mm_set", int'(mismatch_err), 1);
            tick();
         end
         send(0, exp_q[k]);
      end
      check_run();
      chk("mm_run", int'(mismatch_err), 1);
      finish(0, 0);
      tick();
      chk("mm_sticky", int'(mismatch_err), 1);
      // timeout: no core_finish at all
      for (int k = 0; k < 8; k++) begin
         exp_q[k] = -k - 1;
         send(1, exp_q[k]);
      end
      check_run();
      for (int i = 1; i < 64; i++) begin
         tick();
         chk("to_lo", int'(timeout_err), 0);
         chk("to_rdy_lo", int'(in_ready), 0);
      end
      tick();
      chk("to_hi", int'(timeout_err), 1);
      chk("to_no_done", int'(frame_done), 0);
      chk("to_rdy", int'(in_ready), 1);
      tick();
      chk("to_pulse", int'(timeout_err), 0);
      // backpressure: held sample waits through RUN/WAIT, accepted in frame_done cycle
      for (int k = 0; k < 8; k++) begin
         exp_q[k] = 256 + k;
         send(0, exp_q[k]);
      end
      in_valid   = 1'b1;
      in_channel = 1'b1;
      in_sample  = 16'h7777;
      check_run();
      tick();
      tick();
      chk("bp_rdy", int'(in_ready), 0);
      core_finish = 1'b1;
      tick();
      core_finish = 1'b0;
      chk("bp_done", int'(frame_done), 1);
      chk("bp_done_rdy", int'(in_ready), 1);
      chk("bp_done_ch", int'(frame_channel), 0);
      tick();
      chk("bp_latch_ch", int'(frame_channel), 1);
      exp_q[0] = 30583;
      for (int k = 1; k < 8; k++) begin
         exp_q[k] = -300 * k;
         send(1, exp_q[k]);
      end
      check_run();
      finish(0, 1);
      tick();
      // reset in the third RUN cycle
      for (int k = 0; k < 8; k++) begin
         exp_q[k] = 7 * k;
         send(1, exp_q[k]);
      end
      tick();
      tick();
      chk("mr_en_pre", int'(core_enable), 1);
      chk("mr_idx_pre", int'(core_index), 2);
      RESET = 1'b1;
      #1;
      chk("mr_en", int'(core_enable), 0);
      chk("mr_smp", int'(core_sample), 0);
      chk("mr_idx", int'(core_index), 0);
      chk("mr_fch", int'(frame_channel), 0);
      chk("mr_mm", int'(mismatch_err), 0);
      chk("mr_done", int'(frame_done), 0);
      #2 RESET = 1'b0;
      tick();
      chk("mr_rdy", int'(in_ready), 1);
      for (int k = 0; k < 8; k++) begin
         exp_q[k] = 1000 - k;
         send(0, exp_q[k]);
      end
      check_run();
      finish(1, 0);
      tick();
      // wide instance: channel 3, signed values -8..7
      p_in_valid   = 1'b1;
      p_in_channel = 2'd3;
      for (int k = 0; k < 16; k++) begin
         p_in_sample = 24'(k - 8);
         chk("p_rdy", int'(p_in_ready), 1);
         tick();
      end
      p_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("p_en", int'(p_core_enable), 1);
         chk("p_idx", int'(p_core_index), k);
         chk("p_smp", int'($signed(p_core_sample)), k - 8);
         tick();
      end
      chk("p_wait_en", int'(p_core_enable), 0);
      chk("p_fch", int'(p_frame_channel), 3);
      p_core_finish = 1'b1;
      tick();
      p_core_finish = 1'b0;
      chk("p_done", int'(p_frame_done), 1);
      chk("p_mm", int'(p_mismatch_err), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Parametrised frame sequencer between a multi-channel sample stream and the FFT core. It collects one frame of `N_POINTS` signed time samples for a single channel over a valid/ready handshake and replays the frame into the core on consecutive cycles under `core_enable`. It then waits for `core_finish` and reports completion per channel, with a completion timeout. It is the next-generation front end for the FFT datapath: depth, width and channel count are parameters, and backpressure and error reporting are added.

## Interface
- `DATA_W`, 16: sample width, two's complement.
- `N_POINTS`, 8: frame length; power of two, ≥4.
- `CHANNELS`, 2: number of input channels, ≥1.
- `TIMEOUT`, 64: maximum WAIT cycles for `core_finish`, ≥1.
- Derived: `IDX_W = $clog2(N_POINTS)`; `CH_W = max(1, $clog2(CHANNELS))`.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sequencer can accept a sample.
- `in_channel`  in  CH_W  channel tag of the offered sample.
- `in_sample`  in  DATA_W  signed sample.
- `core_enable`  out  1  a core sample is valid this cycle.
- `core_sample`  out  DATA_W  sample driven to the core.
- `core_index`  out  IDX_W  position of `core_sample` in the frame.
- `core_finish`  in  1  core completion (level or pulse).
- `frame_done`  out  1  one-cycle pulse: frame completed.
- `frame_channel`  out  CH_W  channel of the current/last frame.
- `timeout_err`  out  1  one-cycle pulse: core did not finish in time.
- `mismatch_err`  out  1  sticky: a sample with a wrong channel was dropped.

## Operation
- FSM states: IDLE, FILL, RUN, WAIT.
- **IDLE:** `in_ready`=1. The first accepted sample (`in_valid & in_ready`) latches `in_channel` into `frame_channel`, writes `buf[0]`, sets `wr_cnt`=1 and moves to FILL.
- **FILL:** `in_ready`=1.
  - An accepted sample whose channel equals `frame_channel` is written to `buf[wr_cnt]` and increments `wr_cnt`.
  - An accepted sample with a different channel is consumed and dropped; it sets `mismatch_err`.
  - When the `N_POINTS`-th matching sample is accepted, move to RUN.
- **RUN:** `in_ready`=0.
  - For `k` = 0 … N_POINTS−1 on consecutive cycles: `core_enable`=1, `core_sample`=`buf[k]`, `core_index`=k.
  - After index N_POINTS−1, move to WAIT.
  - `core_finish` is ignored in RUN.
- **WAIT:** `in_ready`=0, `core_enable`=0, timeout counter counts from 0.
  - `core_finish`=1 → `frame_done` pulses next cycle, go to IDLE.
  - Counter reaches TIMEOUT−1 without finish → `timeout_err` pulses next cycle, go to IDLE, no `frame_done`.
  - If finish and timeout occur in the same cycle, finish wins.
- `mismatch_err` clears only on `RESET`.
- `core_sample` and `core_index` hold their last value when `core_enable`=0.

## Timing
- **Reset values:** state IDLE; `in_ready`=1 (combinational from state, so high once `RESET` is low); `core_enable`=0; `core_sample`=0; `core_index`=0; `frame_done`=0; `frame_channel`=0; `timeout_err`=0; `mismatch_err`=0; counters 0.
- **Input to RUN:** the first `core_enable` cycle is the cycle after the edge that accepts the last sample.
- **Frame latency:** with no stalls and no mismatches, the last sample is accepted at edge N_POINTS. RUN occupies cycles N_POINTS+1 … 2·N_POINTS. WAIT starts at 2·N_POINTS+1.
- **Completion timing:** `frame_done` or `timeout_err` is registered and high for exactly one cycle. IDLE, with `in_ready`=1, is re-entered in that same cycle.
- **Back-to-back frames:** a sample may be accepted in the `frame_done` cycle.
- **Reset mid-operation:** `RESET` asserted in any state aborts immediately. The partial frame is discarded, and `core_enable` drops asynchronously.
- **Width rules:** samples are stored and forwarded unmodified; no arithmetic on data.

## Structure
- Package `fft_pkg`:
  - state enum `seq_state_t` {IDLE, FILL, RUN, WAIT};
  - `function automatic int ch_width(int)`.
- Sub-module `fft_frame_buf`: N_POINTS×DATA_W register file, one write port, one registered read port. The read address is issued one cycle ahead so that `core_sample` is registered.
- Top-level `fft_frame_sequencer` holds the FSM, counters and flags.

## Test plan
- **Basic frame:** defaults; channel 1, samples 1..8 back-to-back; `core_finish` 5 cycles into WAIT → `core_sample` 1..8 with `core_index` 0..7 on 8 consecutive cycles; then one `frame_done` with `frame_channel`=1.
- **Stalls and mismatches:** channel 0 frame with `in_valid` toggling every other cycle and one channel-1 sample inserted → frame contains only the 8 channel-0 values; `mismatch_err`=1 and stays 1.
- **Timeout:** `core_finish` never asserted → `timeout_err` pulses exactly at TIMEOUT cycles after WAIT entry; no `frame_done`; `in_ready` back to 1.
- **Backpressure:** `in_valid` held high through RUN/WAIT → `in_ready`=0 and nothing accepted; the held sample is accepted in the `frame_done` cycle as index 0 of the next frame.
- **Reset mid-operation:** `RESET` pulsed in the 3rd RUN cycle → `core_enable`=0 immediately; all outputs at reset values; a fresh full frame then completes normally.
- **Parametrisation:** `N_POINTS`=16, `DATA_W`=24, `CHANNELS`=4; channel 3 with values −8..7 → 16 `core_enable` cycles carrying the exact signed values; `frame_channel`=3.
